uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter NUM_BITS SHALL default to 8 and set the data bits per frame; legal range is 2 to 16.
REQ-003 Parameter BIT_PERIOD SHALL default to 10 and set the clock cycles per serial bit; legal range is 2 to 1023.
REQ-004 Parameter SHIFT_MSB SHALL default to 0 (0 = LSB transmitted first, 1 = MSB transmitted first).
REQ-005 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  SHALL be the synchronous active-high reset.
REQ-007 Port tx_data  input  NUM_BITS  SHALL be the parallel word to send, sampled only on an accepted start.
REQ-008 Port tx_start  input  1  SHALL request a frame; it is a level, sampled every cycle.
REQ-009 Port tx_busy  output  1  SHALL be high while a frame is in progress.
REQ-010 Port tx_done  output  1  SHALL be a one-cycle pulse marking the final cycle of a frame.
REQ-011 Port serial_out  output  1  SHALL be the serial line, driven from a register and idle-high.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when the option is compiled in.
REQ-013 In IDLE with tx_start high at edge k, the block SHALL latch tx_data into a shift register, enter START, and drive tx_busy=1 and serial_out=0 from edge k.
REQ-014 Each bit SHALL be held on serial_out for exactly BIT_PERIOD cycles, timed by an internal counter that counts 0..BIT_PERIOD-1 and wraps.
REQ-015 START SHALL last one bit period, then move to DATA.
REQ-016 DATA SHALL last NUM_BITS bit periods and shift out the latched word in SHIFT_MSB order, using an internal bit counter.
REQ-017 STOP SHALL drive serial_out=1 for one bit period and assert tx_done in its last cycle.
REQ-018 After STOP, the FSM SHALL return to IDLE and drive tx_busy=0 at the next edge.
REQ-019 Frame length SHALL be (NUM_BITS+2)*BIT_PERIOD cycles of tx_busy high, or (NUM_BITS+3)*BIT_PERIOD with parity.
REQ-020 tx_start SHALL be ignored while tx_busy=1, including the tx_done cycle, so a start is accepted no earlier than the first IDLE cycle.
REQ-021 Changes on tx_data during a frame SHALL NOT affect the frame in progress.
REQ-022 With tx_start held high continuously, frames SHALL repeat back-to-back with exactly one idle-high cycle between them.
REQ-023 In IDLE, serial_out SHALL be 1, tx_busy 0 and tx_done 0.

Reset
REQ-024 rst high at an edge SHALL force IDLE with serial_out=1, tx_busy=0 and tx_done=0, clearing both counters and the shift register to all-ones.
REQ-025 rst asserted mid-frame SHALL abort the frame on that edge with no tx_done pulse.
REQ-026 rst SHALL take priority over tx_start in the same cycle.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: a PARITY state SHALL follow DATA for one bit period, driving the even-parity bit (XOR of the latched word).
REQ-028 Macro UART_TX_PARITY_EN undefined: no PARITY state or parity logic SHALL exist, and DATA SHALL go directly to STOP.

Verification (defaults NUM_BITS=8, BIT_PERIOD=10, SHIFT_MSB=0)
REQ-029 tx_data=0x96 with one-cycle tx_start -> serial_out bit sequence 0,0,1,1,0,1,0,0,1,1, 10 cycles each; tx_busy high for 100 cycles; tx_done high in cycle 100 only.
REQ-030 SHIFT_MSB=1, tx_data=0x96 -> data bits 1,0,0,1,0,1,1,0 between the start bit 0 and the stop bit 1.
REQ-031 UART_TX_PARITY_EN defined: 0x96 -> parity bit 0; 0x07 -> parity bit 1; tx_busy high for 110 cycles.
REQ-032 rst pulsed at frame cycle 35 -> next edge serial_out=1, tx_busy=0, no tx_done; a new tx_start then produces a full, correct frame.
REQ-033 tx_start pulsed at frame cycles 20 and 100 with tx_data changed to 0xFF -> both pulses ignored, the frame is unchanged, and the line is idle at cycle 101.
REQ-034 tx_start held high for 250 cycles -> back-to-back frames, each 100 cycles long, separated by one idle-high cycle, with two tx_done pulses in the window.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: parameterised UART frame serialiser.
//
// Frame: start bit (0), NUM_BITS data bits, optional even-parity bit, and a
// stop bit (1). Each bit lasts BIT_PERIOD clock cycles. The data bits go out
// LSB first (SHIFT_MSB = 0) or MSB first (SHIFT_MSB = 1).
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the data bits. When the macro is undefined, no parity state and no parity
// logic are built.
//
// Ports:
//   clk         single clock; all state changes on its rising edge
//   rst         synchronous active-high reset
//   tx_data     parallel word to send; captured only when a start is accepted
//   tx_start    start request (level); honoured only in IDLE
//   tx_busy     high while a frame is in progress
//   tx_done     one-cycle pulse during the final cycle of the stop bit
//   serial_out  registered serial line; idles high
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for tx_start
// START | start bit (0) for one bit period
// DATA  | NUM_BITS data bits, one bit period each
// PARITY| even-parity bit (only with UART_TX_PARITY_EN)
// STOP  | stop bit (1) for one bit period; tx_done in the last cycle

module uart_transmitter #(
    parameter int NUM_BITS   = 8,
    parameter int BIT_PERIOD = 10,
    parameter int SHIFT_MSB  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_start,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                serial_out
);

    localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [BIT_W-1:0]    bit_q, bit_n;
    logic [NUM_BITS-1:0] shreg_q, shreg_n;
    logic                serial_q, serial_n;

    logic                bit_end;
    logic [NUM_BITS-1:0] shifted;
    logic                head_bit;
    logic                next_bit;

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    // Parity is taken from the word as captured, since the shift register
    // is refilled with ones as the data shifts out.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (state_q == S_IDLE && tx_start) begin
            parity_q <= ^tx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '1;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            bit_q    <= bit_n;
            shreg_q  <= shreg_n;
            serial_q <= serial_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = '0;
        bit_n    = bit_q;
        shreg_n  = shreg_q;
        serial_n = serial_q;

        bit_end  = (cnt_q == CNT_LAST);
        shifted  = (SHIFT_MSB != 0) ? {shreg_q[NUM_BITS-2:0], 1'b1}
                                    : {1'b1, shreg_q[NUM_BITS-1:1]};
        head_bit = (SHIFT_MSB != 0) ? shreg_q[NUM_BITS-1] : shreg_q[0];
        next_bit = (SHIFT_MSB != 0) ? shifted[NUM_BITS-1] : shifted[0];

        case (state_q)
            S_IDLE: begin
                serial_n = 1'b1;
                if (tx_start) begin
                    state_n  = S_START;
                    shreg_n  = tx_data;
                    bit_n    = '0;
                    serial_n = 1'b0;
                end
            end
            S_START: begin
                cnt_n = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_n  = S_DATA;
                    serial_n = head_bit;
                end
            end
            S_DATA: begin
                cnt_n = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    shreg_n = shifted;
                    if (bit_q == BIT_LAST) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n  = S_PARITY;
                        serial_n = parity_q;
`else
                        state_n  = S_STOP;
                        serial_n = 1'b1;
`endif
                    end else begin
                        bit_n    = bit_q + 1'b1;
                        serial_n = next_bit;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                cnt_n = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_n  = S_STOP;
                    serial_n = 1'b1;
                end
            end
`endif
            S_STOP: begin
                cnt_n    = bit_end ? '0 : cnt_q + 1'b1;
                serial_n = 1'b1;
                if (bit_end) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n  = S_IDLE;
                serial_n = 1'b1;
            end
        endcase
    end

    assign tx_busy    = (state_q != S_IDLE);
    assign tx_done    = (state_q == S_STOP) && bit_end;
    assign serial_out = serial_q;

endmodule
